// File: rtl/rxreq_slc_multi_pkg.sv
// Shared types for the RXREQ multi-stage slice: the request flit layout and the slice depth limit.
package rxreq_slc_multi_pkg;

    typedef struct packed {
        logic [10:0] src_id;
        logic [11:0] txn_id;
        logic [6:0]  opcode;
        logic [2:0]  size;
        logic [51:0] addr;
        logic        ns;
        logic        allow_retry;
        logic [3:0]  pcrd_type;
    } reqflit_t;

    localparam int REQFLIT_W           = $bits(reqflit_t);
    localparam int RXREQ_SLC_MAX_DEPTH = 8;

endpackage

// File: rtl/rxreq_slc_stage.sv
// One RXREQ slice stage: a plain pipe register, or with RXREQ_SLC_SKID_EN defined a
// main+skid register pair whose upstream ready comes straight from a flop.
module rxreq_slc_stage
    import rxreq_slc_multi_pkg::*;
#(
    parameter int WIDTH = REQFLIT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             in_fire;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign in_fire   = in_valid & in_ready;

    // NOTE: data registers are never reset; the valid bits alone say whether they hold a flit.
    // NOTE: all state uses <= so each flop samples the pre-edge values of its neighbours.
`ifdef RXREQ_SLC_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             main_free;

    assign in_ready  = ~skid_valid;
    assign main_free = ~main_valid | out_ready;

    // A parked skid flit refills main first; in_ready is low while it is parked.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            main_valid <= skid_valid | in_fire;
            skid_valid <= 1'b0;
        end else if (in_fire) begin
            skid_valid <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (main_free) begin
            main_data <= skid_valid ? skid_data : in_data;
        end else if (in_fire) begin
            skid_data <= in_data;
        end
    end
`else
    assign in_ready = ~main_valid | out_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            main_valid <= 1'b0;
        end else if (in_ready) begin
            main_valid <= in_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (in_fire) begin
            main_data <= in_data;
        end
    end
`endif

endmodule

// File: rtl/rxreq_slc_multi.sv
// DEPTH-stage valid/ready slice for RXREQ flits with synchronous flush and an occupancy count.
// Define RXREQ_SLC_SKID_EN to give every stage a skid register and a registered ready.
module rxreq_slc_multi
    import rxreq_slc_multi_pkg::*;
#(
    parameter int WIDTH = REQFLIT_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(2*DEPTH+1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             pin_valid,
    output logic             pin_ready,
    input  logic [WIDTH-1:0] pin_data,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic [WIDTH-1:0] pout_data,
    output logic [CNT_W-1:0] occupancy
);
    if (DEPTH < 1 || DEPTH > RXREQ_SLC_MAX_DEPTH) begin : g_depth_check
        $error("rxreq_slc_multi: DEPTH must lie in 1..%0d", RXREQ_SLC_MAX_DEPTH);
    end

    // Stage 0 faces the POCQ head, stage DEPTH-1 drives the decode/allocate side.
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             in_valid;
        logic             in_ready;
        logic [WIDTH-1:0] in_data;
        logic             out_valid;
        logic             out_ready;
        logic [WIDTH-1:0] out_data;

        if (g == 0) begin : g_from_port
            assign in_valid = pin_valid;
            assign in_data  = pin_data;
        end else begin : g_from_stage
            assign in_valid = g_stage[g-1].out_valid;
            assign in_data  = g_stage[g-1].out_data;
        end

        if (g == DEPTH - 1) begin : g_to_port
            assign out_ready = pout_ready;
        end else begin : g_to_stage
            assign out_ready = g_stage[g+1].in_ready;
        end

        rxreq_slc_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clock    (clock),
            .reset    (reset),
            .flush    (flush),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_data  (in_data),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_data (out_data)
        );
    end

    logic pin_fire;
    logic pout_fire;

    // Both ports go quiet during flush or reset so nothing transfers while state is discarded.
    assign pin_ready  = g_stage[0].in_ready & ~flush & ~reset;
    assign pout_valid = g_stage[DEPTH-1].out_valid & ~flush & ~reset;
    assign pout_data  = g_stage[DEPTH-1].out_data;

    assign pin_fire  = pin_valid & pin_ready;
    assign pout_fire = pout_valid & pout_ready;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            occupancy <= '0;
        end else if (pin_fire && !pout_fire) begin
            occupancy <= occupancy + CNT_W'(1);
        end else if (!pin_fire && pout_fire) begin
            occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rxreq_slc_multi.sv
// Bench for rxreq_slc_multi: directed vectors on a DEPTH=2 slice, then random traffic on
// DEPTH=1,2,4,8 slices against a FIFO scoreboard. Build with or without RXREQ_SLC_SKID_EN.
module tb_rxreq_slc_multi;
    localparam int N_DUT         = 4;
    localparam int STRESS_CYCLES = 10000;
    localparam int MAIN          = 1;   // index of the DEPTH=2 slice
`ifdef RXREQ_SLC_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       flush      [N_DUT];
    logic       pin_valid  [N_DUT];
    logic       pin_ready  [N_DUT];
    logic [7:0] pin_data   [N_DUT];
    logic       pout_valid [N_DUT];
    logic       pout_ready [N_DUT];
    logic [7:0] pout_data  [N_DUT];
    logic [4:0] occ        [N_DUT];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        rxreq_slc_multi #(
            .WIDTH(8),
            .DEPTH(1 << g),
            .CNT_W(5)
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .flush     (flush[g]),
            .pin_valid (pin_valid[g]),
            .pin_ready (pin_ready[g]),
            .pin_data  (pin_data[g]),
            .pout_valid(pout_valid[g]),
            .pout_ready(pout_ready[g]),
            .pout_data (pout_data[g]),
            .occupancy (occ[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int occ_max(input int depth);
        return SKID ? 2 * depth : depth;
    endfunction

    // Drive one cycle on the DEPTH=2 slice and check its outputs mid-cycle.
    task automatic vec(input string tag, input logic pv, input logic [7:0] pd, input logic pr,
                       input logic fl, input logic epr, input logic epv, input logic [7:0] epd,
                       input int eocc);
        pin_valid[MAIN]  = pv;
        pin_data[MAIN]   = pd;
        pout_ready[MAIN] = pr;
        flush[MAIN]      = fl;
        @(negedge clock);
        check({tag, ".pin_ready"}, 32'(pin_ready[MAIN]), 32'(epr));
        check({tag, ".pout_valid"}, 32'(pout_valid[MAIN]), 32'(epv));
        if (epv) check({tag, ".pout_data"}, 32'(pout_data[MAIN]), 32'(epd));
        check({tag, ".occupancy"}, 32'(occ[MAIN]), 32'(eocc));
        @(posedge clock);
        #1;
    endtask

    task automatic stress();
        int         head      [N_DUT];
        int         cnt       [N_DUT];
        logic [7:0] mem       [N_DUT][32];
        logic       in_f      [N_DUT];
        logic       out_f     [N_DUT];
        logic       fl        [N_DUT];
        logic       hold      [N_DUT];
        logic [7:0] din       [N_DUT];
        logic [7:0] hold_data [N_DUT];
        int         ready_bias = 50;

        for (int i = 0; i < N_DUT; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
            hold[i] = 1'b0;
        end

        for (int cyc = 0; cyc < STRESS_CYCLES && n_errors <= 30; cyc++) begin
            if (cyc % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       ready_bias = 10;
                    1:       ready_bias = 50;
                    default: ready_bias = 95;
                endcase
            end
            for (int i = 0; i < N_DUT; i++) begin
                pin_valid[i]  = ($urandom_range(0, 99) < 60);
                pin_data[i]   = 8'($urandom);
                pout_ready[i] = ($urandom_range(0, 99) < ready_bias);
                flush[i]      = ($urandom_range(0, 63) == 0);
            end

            @(negedge clock);
            for (int i = 0; i < N_DUT; i++) begin
                string t;
                int    d;
                d = 1 << i;
                t = $sformatf("stress.d%0d.c%0d", d, cyc);
                check({t, ".occupancy"}, 32'(occ[i]), 32'(cnt[i]));
                if (flush[i]) begin
                    check({t, ".flush_pin_ready"}, 32'(pin_ready[i]), 32'(0));
                    check({t, ".flush_pout_valid"}, 32'(pout_valid[i]), 32'(0));
                end else begin
                    if (cnt[i] == 0) begin
                        check({t, ".empty_pin_ready"}, 32'(pin_ready[i]), 32'(1));
                        check({t, ".empty_pout_valid"}, 32'(pout_valid[i]), 32'(0));
                    end
                    if (cnt[i] == occ_max(d) && (SKID || !pout_ready[i]))
                        check({t, ".full_pin_ready"}, 32'(pin_ready[i]), 32'(0));
                    if (hold[i]) begin
                        check({t, ".stall_valid"}, 32'(pout_valid[i]), 32'(1));
                        check({t, ".stall_data"}, 32'(pout_data[i]), 32'(hold_data[i]));
                    end
                end
                if (pout_valid[i] && cnt[i] > 0)
                    check({t, ".order"}, 32'(pout_data[i]), 32'(mem[i][head[i]]));
                in_f[i]      = pin_valid[i] & pin_ready[i];
                out_f[i]     = pout_valid[i] & pout_ready[i];
                fl[i]        = flush[i];
                din[i]       = pin_data[i];
                hold[i]      = pout_valid[i] & ~pout_ready[i];
                hold_data[i] = pout_data[i];
            end

            @(posedge clock);
            #1;
            for (int i = 0; i < N_DUT; i++) begin
                if (fl[i]) begin
                    cnt[i] = 0;
                end else begin
                    if (out_f[i] && cnt[i] > 0) begin
                        head[i] = (head[i] + 1) % 32;
                        cnt[i]  = cnt[i] - 1;
                    end
                    if (in_f[i]) begin
                        mem[i][(head[i] + cnt[i]) % 32] = din[i];
                        cnt[i] = cnt[i] + 1;
                    end
                end
            end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            flush[i]      = 1'b0;
            pin_valid[i]  = 1'b0;
            pin_data[i]   = 8'h00;
            pout_ready[i] = 1'b0;
        end

        // Reset held across several edges; the slice must refuse input throughout.
        repeat (3) begin
            @(negedge clock);
            check("reset.pin_ready", 32'(pin_ready[MAIN]), 32'(0));
            @(posedge clock);
        end
        #1 reset = 1'b0;
        vec("idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);

        // Back-to-back stream: a flit presented in cycle 0 is at the head in cycle DEPTH.
        vec("stream0", 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        vec("stream1", 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        vec("stream2", 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 2);
        vec("stream3", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2);
        vec("stream4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1);
        vec("stream5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);

        // Backpressure fill, then drain in order.
`ifdef RXREQ_SLC_SKID_EN
        vec("bp0",  1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        vec("bp1",  1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        vec("bp2",  1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 2);
        vec("bp3",  1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 3);
        vec("bp4",  1'b1, 8'hA4, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 4);
        vec("bp5",  1'b1, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA0, 4);
        vec("bp6",  1'b1, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 3);
        vec("bp7",  1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 2);
        vec("bp8",  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 2);
        vec("bp9",  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, 1);
        vec("bp10", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);
`else
        vec("bp0",  1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        vec("bp1",  1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        vec("bp2",  1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 2);
        vec("bp3",  1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 2);
        vec("bp4",  1'b1, 8'hA2, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 2);
        vec("bp5",  1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 2);
        vec("bp6",  1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 2);
        vec("bp7",  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA3, 2);
        vec("bp8",  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, 1);
        vec("bp9",  1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);
`endif

        // Flush with two flits held and 0x55 offered; 0x66 must be the next flit out.
        vec("flush0", 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        vec("flush1", 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        vec("flush2", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2);
        vec("flush3", 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        vec("flush4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        vec("flush5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h66, 1);
        vec("flush6", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);

        // Reset while stalled with two flits held; nothing stale may appear afterwards.
        vec("rst0", 1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        vec("rst1", 1'b1, 8'hC1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1);
        reset              = 1'b1;
        pin_valid[MAIN]    = 1'b0;
        pout_ready[MAIN]   = 1'b0;
        @(negedge clock);
        check("rst2.pin_ready", 32'(pin_ready[MAIN]), 32'(0));
        check("rst2.occupancy", 32'(occ[MAIN]), 32'(2));
        @(posedge clock);
        #1 reset = 1'b0;
        vec("rst3", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        vec("rst4", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);
        vec("rst5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0);

        stress();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
